// File: rtl/decimating_averager.sv
// Block averager: sums 2^k consecutive signed samples and emits one rounded
// (round-half-up) mean per block with a single-cycle valid strobe.
module decimating_averager #(
  parameter int WIDTH    = 16,
  parameter int LOG2_MAX = 10,
  parameter int K_WIDTH  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic signed [WIDTH-1:0] data_i,
  input  logic [K_WIDTH-1:0]      log2n_i,
  input  logic                    clear_i,
  output logic signed [WIDTH-1:0] data_o,
  output logic                    valid_o
);

  // One guard bit beyond WIDTH+LOG2_MAX keeps the rounding add from wrapping.
  localparam int ACC_W = WIDTH + LOG2_MAX + 1;

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_MAX-1:0]        cnt_q, cnt_d;
  logic [K_WIDTH-1:0]         k_q, k_d;
  logic signed [WIDTH-1:0]    data_q, data_d;
  logic                       valid_q, valid_d;

  logic [K_WIDTH-1:0]         k_req, k_eff;
  logic [LOG2_MAX-1:0]        cnt_last;
  logic signed [ACC_W-1:0]    sum, half, rnd;

  always_comb begin
    k_req    = (log2n_i > K_WIDTH'(LOG2_MAX)) ? K_WIDTH'(LOG2_MAX) : log2n_i;
    // The requested exponent is only honoured at a block boundary.
    k_eff    = (cnt_q == '0) ? k_req : k_q;
    cnt_last = ~({LOG2_MAX{1'b1}} << k_eff);
    sum      = acc_q + {{(ACC_W-WIDTH){data_i[WIDTH-1]}}, data_i};
    half     = (k_eff == '0) ? '0 : (ACC_W'(1) << (k_eff - K_WIDTH'(1)));
    rnd      = sum + half;

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    data_d  = data_q;
    valid_d = 1'b0;

    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else begin
      if (cnt_q == '0) k_d = k_eff;
      if (cnt_q == cnt_last) begin
        data_d  = WIDTH'(rnd >>> k_eff);
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_decimating_averager.sv
// Bench for decimating_averager: directed scenarios plus random traffic, all
// checked against a block-level arithmetic model of the averager.
module tb_decimating_averager;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic signed [15:0] data_i;
  logic [3:0]         log2n_i;
  logic               clear_i;
  logic signed [15:0] data_o;
  logic               valid_o;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: samples collected per block, length fixed at block start.
  longint m_sum, m_len, m_cnt, m_data;
  bit     m_valid;

  decimating_averager #(.WIDTH(16), .LOG2_MAX(10), .K_WIDTH(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .log2n_i (log2n_i),
    .clear_i (clear_i),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint rmean(input longint s, input longint n);
    longint t, q;
    t = s + n / 2;
    q = t / n;
    if ((t % n != 0) && (t < 0)) q--;
    return q;
  endfunction

  task automatic model_reset();
    m_sum = 0; m_len = 1; m_cnt = 0; m_data = 0; m_valid = 0;
  endtask

  // Drive one sample, let the edge consume it, advance the model, check outputs.
  task automatic step(input int d, input int k, input bit c);
    data_i  = 16'(d);
    log2n_i = 4'(k);
    clear_i = c;
    @(posedge clk_i);
    if (c) begin
      m_sum = 0; m_cnt = 0; m_valid = 0;
    end else begin
      if (m_cnt == 0) m_len = longint'(1) << ((k > 10) ? 10 : k);
      m_sum += d;
      m_cnt++;
      if (m_cnt == m_len) begin
        m_data = rmean(m_sum, m_len);
        m_valid = 1;
        m_sum = 0; m_cnt = 0;
      end else m_valid = 0;
    end
    #1;
    chk("valid", valid_o, m_valid);
    chk("data", data_o, m_data);
  endtask

  task automatic run8(input int k, input int a0, a1, a2, a3, a4, a5, a6, a7);
    step(a0, k, 0); step(a1, k, 0); step(a2, k, 0); step(a3, k, 0);
    step(a4, k, 0); step(a5, k, 0); step(a6, k, 0); step(a7, k, 0);
  endtask

  initial begin
    int pulses, k, lp, prev;
    bit mono;
    rst_i = 1'b1; data_i = '0; log2n_i = '0; clear_i = 1'b0;
    model_reset();
    #12;
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Constant 1000, k=3: pulse every 8 samples.
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      step(1000, 3, 0);
      if (valid_o) begin
        pulses++;
        chk("const_val", data_o, 1000);
        chk("const_pos", i % 8, 7);
      end
    end
    chk("const_pulses", pulses, 3);

    // Rounding cases.
    run8(3, 1, 1, 1, 1, 0, 0, 0, 0);         chk("round_p4", data_o, 1);
    run8(3, -1, -1, -1, -1, 0, 0, 0, 0);     chk("round_m4", data_o, 0);
    run8(3, -1, -1, -1, -1, -1, 0, 0, 0);    chk("round_m5", data_o, -1);

    // Extremes at k=10 and clamp of k=15.
    for (int i = 0; i < 1024; i++) step(32767, 10, 0);
    chk("max", data_o, 32767);
    for (int i = 0; i < 1024; i++) step(-32768, 10, 0);
    chk("min", data_o, -32768);
    pulses = 0;
    for (int i = 0; i < 2048; i++) begin
      step(int'($urandom_range(0, 65535)) - 32768, 15, 0);
      if (valid_o) pulses++;
    end
    chk("clamp_pulses", pulses, 2);

    // Mid-block k change: block in flight stays at 4 samples.
    step(0, 2, 1);
    step(40, 2, 0); step(40, 2, 0);
    pulses = 0;
    for (int i = 0; i < 34; i++) begin
      step(40, 4, 0);
      if (valid_o) begin
        pulses++;
        chk("kchg_pos", i % 16, 1);
      end
    end
    chk("kchg_pulses", pulses, 3);

    // Clear mid-block: data holds, next block completes 8 samples later.
    step(0, 3, 1);
    run8(3, 100, 100, 100, 100, 100, 100, 100, 100);
    chk("pre_clr", data_o, 100);
    for (int i = 0; i < 4; i++) step(200, 3, 0);
    step(200, 3, 1);
    chk("clr_hold", data_o, 100);
    chk("clr_novalid", valid_o, 0);
    run8(3, 200, 200, 200, 200, 200, 200, 200, 200);
    chk("post_clr", data_o, 200);

    // Async reset between edges mid-block.
    for (int i = 0; i < 3; i++) step(500, 3, 0);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_data", data_o, 0);
    chk("arst_valid", valid_o, 0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(500, 3, 0);
      if (valid_o) begin pulses++; chk("arst_pos", i, 7); end
    end
    chk("arst_pulses", pulses, 1);

    // First-order low-pass (alpha = 1/2) step response into the averager.
    step(0, 4, 1);
    lp = 0; prev = -40000; mono = 1;
    for (int i = 0; i < 160; i++) begin
      lp = lp + ((8000 - lp) >>> 1);
      step(lp, 4, 0);
      if (valid_o) begin
        if (data_o < prev) mono = 0;
        prev = data_o;
      end
    end
    chk("lp_monotonic", mono, 1);
    chk("lp_converge", (data_o >= 7999 && data_o <= 8001), 1);

    // Random traffic: random samples, exponents, clears.
    for (int i = 0; i < 3000; i++) begin
      k = (i % 37 == 0) ? int'($urandom_range(0, 6)) : k;
      if (i == 0) k = 2;
      step(int'($urandom_range(0, 65535)) - 32768,
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : k,
           ($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/decimating_averager.md
Name: decimating_averager

Overview:
- Sits directly downstream of low_pass_v2 and consumes its per-clock filtered output data_o.
- Averages consecutive blocks of 2^k samples and emits one rounded mean per block with a one-cycle valid strobe.
- This lowers the sample rate for the slower feedback/logging logic that follows.
- The decimation exponent k is runtime-programmable and takes effect only at block boundaries.

Parameters:
- WIDTH, 16, sample width of data_i and data_o (signed two's complement).
- LOG2_MAX, 10, maximum decimation exponent; the largest block is 2^LOG2_MAX samples.
- K_WIDTH, 4, width of log2n_i; must satisfy 2^K_WIDTH > LOG2_MAX.

Ports:
- clk_i  input  1  system clock; one input sample per rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- data_i  input  WIDTH  signed sample, normally low_pass_v2 data_o.
- log2n_i  input  K_WIDTH  requested decimation exponent k (block length N = 2^k).
- clear_i  input  1  synchronous restart of the current block.
- data_o  output  WIDTH  signed rounded block mean.
- valid_o  output  1  high for exactly one cycle when data_o is updated.

Behaviour:
- Reset (async assert, any cycle): data_o=0, valid_o=0, acc=0, cnt=0, k_reg=0.
  - The first sample accepted is data_i at the first rising edge with rst_i low.
- Internal state:
  - acc: signed, WIDTH+LOG2_MAX+1 bits; cannot overflow at any k.
  - cnt: LOG2_MAX bits.
  - k_reg: active exponent.
- Effective exponent k_eff:
  - When cnt==0, k_eff = min(log2n_i, LOG2_MAX); this is the block boundary.
  - Otherwise k_eff = k_reg.
  - Each edge with cnt==0 and no clear also loads k_reg <= k_eff.
  - Changing log2n_i mid-block has no effect until the next boundary.
- Every rising edge (rst_i low, clear_i low):
  - sum = acc + sext(data_i).
  - If cnt == 2^k_eff − 1 (block end):
    - data_o <= (sum + 2^(k_eff−1)) >>> k_eff, where the +term is 0 when k_eff=0.
    - Rounding is round-half-up, e.g. −0.5 → 0 and +0.5 → 1.
    - valid_o <= 1, acc <= 0, cnt <= 0.
  - Else: acc <= sum, cnt <= cnt+1, valid_o <= 0, data_o holds.
- Latency: data_o/valid_o update on the edge that consumes the last sample of a block, i.e. visible one cycle after that sample is presented.
- k=0: pass-through with 1-cycle register delay; valid_o is continuously high.
- Result range: always within [−2^(WIDTH−1), 2^(WIDTH−1)−1], so no saturation logic is needed.
  - N samples of 32767 give 32767.
  - N samples of −32768 give −32768.
- clear_i high at an edge (priority over accumulation):
  - acc <= 0, cnt <= 0, valid_o <= 0, data_o holds.
  - The sample present that cycle is discarded.
  - The next edge starts a fresh block and re-latches k from log2n_i.
- Reset and clear together: reset dominates.
- Reset mid-block: the partial block is discarded and outputs return to their reset values immediately, without waiting for a clock.

Test Plan:
- Constant data_i=1000, log2n_i=3, reset released before edge 0:
  - valid_o pulses after edges 7, 15, 23, … (period 8 cycles, each pulse 1 cycle wide).
  - data_o=1000 at each pulse.
- Rounding, log2n_i=3:
  - Block of samples {1,1,1,1,0,0,0,0} (sum 4) → data_o=1.
  - Block {−1,−1,−1,−1,0,0,0,0} (sum −4) → data_o=0.
  - Block {−1,−1,−1,−1,−1,0,0,0} (sum −5) → data_o=−1.
- Extremes, log2n_i=10:
  - 1024 samples of 32767 → 32767.
  - 1024 samples of −32768 → −32768.
  - log2n_i=15 behaves identically to 10 (clamp, period 1024).
- Mid-block k change:
  - log2n_i=2; change to 4 after the 2nd sample of a block.
  - The current block still closes after 4 samples.
  - The following pulses are spaced 16 cycles apart.
- clear_i asserted for 1 cycle at the 5th sample of an 8-sample block of value 200, with preceding block value 100:
  - No pulse is produced for the interrupted block.
  - data_o holds 100.
  - The next pulse arrives 8 cycles after clear_i deasserts, with data_o=200.
- Async reset pulse mid-block (between clock edges):
  - data_o=0 and valid_o=0 before the next edge.
  - After release, the first pulse occurs after a full 2^k samples.
- Chained with low_pass_v2 (alpha_i=2147483648) driven by a step from 0 to 8000, log2n_i=4:
  - The sequence of data_o values is monotonically non-decreasing and converges to 8000 ±1.
